// File: rtl/riscv_ex_stage.sv
// RV32I execute stage: load-use hazard detect, operand forwarding, ALU/branch compare, EX/MEM register.
// Optional EX_BRANCH_EN: enables branch flag and branch-target adder (tied to 0 otherwise).
module riscv_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [10:0]     EX_signals,
  input  logic [XLEN-1:0] EX_pc,
  input  logic [XLEN-1:0] EX_dataA,
  input  logic [XLEN-1:0] EX_dataB,
  input  logic [XLEN-1:0] EX_imm,
  input  logic [3:0]      EX_func,
  input  logic [4:0]      EX_Rd,
  input  logic [4:0]      ID_Rs1,
  input  logic [4:0]      ID_Rs2,
  input  logic [1:0]      forwardA,
  input  logic [1:0]      forwardB,
  input  logic [XLEN-1:0] dataD,
  output logic            notStall,
  output logic [10:0]     MEM_signals,
  output logic [XLEN-1:0] MEM_branchAddr,
  output logic            MEM_branchFromAlu,
  output logic [XLEN-1:0] MEM_aluResult,
  output logic [XLEN-1:0] MEM_dataB,
  output logic [4:0]      MEM_Rd
);

  typedef struct packed {
    logic [10:0]     sig;
    logic [XLEN-1:0] addr;
    logic            flag;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] data_b;
    logic [4:0]      rd;
  } ex_mem_t;

  ex_mem_t          ex_mem_q, ex_mem_d;
  logic [2:0]       alu_op;
  logic             alu_src;
  logic [XLEN-1:0]  fwd_a, fwd_b, alu_a, alu_b, alu_res, br_target;
  logic [4:0]       shamt;
  logic             alt, br_flag, lt_s, lt_u, eq;

  assign alu_op  = EX_signals[10:8];
  assign alu_src = EX_signals[2];

  assign notStall = !(EX_signals[5] && (EX_Rd != 5'd0) &&
                      ((EX_Rd == ID_Rs1) || (EX_Rd == ID_Rs2)));

  always_comb begin
    fwd_a = EX_dataA;
    fwd_b = EX_dataB;
    if (forwardA == 2'b10)      fwd_a = ex_mem_q.alu;
    else if (forwardA == 2'b01) fwd_a = dataD;
    if (forwardB == 2'b10)      fwd_b = ex_mem_q.alu;
    else if (forwardB == 2'b01) fwd_b = dataD;
  end

  assign alu_a = fwd_a;
  assign alu_b = alu_src ? EX_imm : fwd_b;
  assign shamt = alu_b[4:0];
  assign lt_s  = $signed(alu_a) < $signed(alu_b);
  assign lt_u  = alu_a < alu_b;
  assign eq    = alu_a == alu_b;

  // I-type only honours bit3 for the shift-right pair; addi never subtracts
  assign alt = EX_func[3] &&
               ((alu_op == 3'b010) ? (EX_func[2:0] == 3'b000 || EX_func[2:0] == 3'b101)
                                   : (EX_func[2:0] == 3'b101));

  always_comb begin
    alu_res = '0;
    case (alu_op)
      3'b000: alu_res = alu_a + alu_b;
      3'b001: alu_res = alu_a - alu_b;
      3'b010, 3'b011: begin
        case (EX_func[2:0])
          3'b000: alu_res = alt ? (alu_a - alu_b) : (alu_a + alu_b);
          3'b001: alu_res = alu_a << shamt;
          3'b010: alu_res = {{(XLEN-1){1'b0}}, lt_s};
          3'b011: alu_res = {{(XLEN-1){1'b0}}, lt_u};
          3'b100: alu_res = alu_a ^ alu_b;
          3'b101: alu_res = alt ? $unsigned($signed(alu_a) >>> shamt) : (alu_a >> shamt);
          3'b110: alu_res = alu_a | alu_b;
          default: alu_res = alu_a & alu_b;
        endcase
      end
      3'b100: alu_res = alu_b;
      default: alu_res = '0;
    endcase
  end

`ifdef EX_BRANCH_EN
  always_comb begin
    br_flag = 1'b0;
    if (alu_op == 3'b001) begin
      case (EX_func[2:0])
        3'b000: br_flag = eq;
        3'b001: br_flag = !eq;
        3'b100: br_flag = lt_s;
        3'b101: br_flag = !lt_s;
        3'b110: br_flag = lt_u;
        3'b111: br_flag = !lt_u;
        default: br_flag = 1'b0;
      endcase
    end
  end
  // PC is word-addressed, immediate is a byte offset
  assign br_target = EX_pc + $unsigned($signed(EX_imm) >>> 2);
`else
  logic unused_br;
  assign unused_br = ^{EX_pc, eq};
  assign br_flag   = 1'b0;
  assign br_target = '0;
`endif

  always_comb begin
    ex_mem_d.sig    = EX_signals;
    ex_mem_d.addr   = br_target;
    ex_mem_d.flag   = br_flag;
    ex_mem_d.alu    = alu_res;
    ex_mem_d.data_b = fwd_b;
    ex_mem_d.rd     = EX_Rd;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) ex_mem_q <= '0;
    else        ex_mem_q <= ex_mem_d;
  end

  assign MEM_signals       = ex_mem_q.sig;
  assign MEM_branchAddr    = ex_mem_q.addr;
  assign MEM_branchFromAlu = ex_mem_q.flag;
  assign MEM_aluResult     = ex_mem_q.alu;
  assign MEM_dataB         = ex_mem_q.data_b;
  assign MEM_Rd            = ex_mem_q.rd;

endmodule

// File: tb/tb_riscv_ex_stage.sv
// Scoreboard bench for riscv_ex_stage; expected branch outputs follow EX_BRANCH_EN.
module tb_riscv_ex_stage;
  localparam int XLEN = 32;
`ifdef EX_BRANCH_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            clear = 1'b0;
  logic [10:0]     EX_signals = '0;
  logic [XLEN-1:0] EX_pc = '0, EX_dataA = '0, EX_dataB = '0, EX_imm = '0, dataD = '0;
  logic [3:0]      EX_func = '0;
  logic [4:0]      EX_Rd = '0, ID_Rs1 = '0, ID_Rs2 = '0;
  logic [1:0]      forwardA = '0, forwardB = '0;
  logic            notStall, MEM_branchFromAlu;
  logic [10:0]     MEM_signals;
  logic [XLEN-1:0] MEM_branchAddr, MEM_aluResult, MEM_dataB;
  logic [4:0]      MEM_Rd;

  riscv_ex_stage #(.XLEN(XLEN)) dut (
    .clock(clock), .clear(clear), .EX_signals(EX_signals), .EX_pc(EX_pc),
    .EX_dataA(EX_dataA), .EX_dataB(EX_dataB), .EX_imm(EX_imm), .EX_func(EX_func),
    .EX_Rd(EX_Rd), .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .forwardA(forwardA),
    .forwardB(forwardB), .dataD(dataD), .notStall(notStall), .MEM_signals(MEM_signals),
    .MEM_branchAddr(MEM_branchAddr), .MEM_branchFromAlu(MEM_branchFromAlu),
    .MEM_aluResult(MEM_aluResult), .MEM_dataB(MEM_dataB), .MEM_Rd(MEM_Rd)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [31:0] alu, db, addr;
    logic        flag;
    logic [10:0] sig;
    logic [4:0]  rd;
  } exp_t;

  exp_t sbq[$];
  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, act, exp);
    end
  endtask

  // advance one edge and compare the DUT against the oldest expectation
  task automatic step();
    exp_t e;
    @(posedge clock);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk({e.tag, "_alu"}, MEM_aluResult, e.alu);
      chk({e.tag, "_db"}, MEM_dataB, e.db);
      chk({e.tag, "_flag"}, {31'd0, MEM_branchFromAlu}, {31'd0, e.flag});
      chk({e.tag, "_addr"}, MEM_branchAddr, e.addr);
      chk({e.tag, "_sig"}, {21'd0, MEM_signals}, {21'd0, e.sig});
      chk({e.tag, "_rd"}, {27'd0, MEM_Rd}, {27'd0, e.rd});
    end
  endtask

  task automatic issue(input string tag, input logic [2:0] op, input logic [3:0] fn,
                       input logic src, input logic mw, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [31:0] dd, input logic [31:0] pc, input logic [4:0] rd,
                       input logic [31:0] e_alu, input logic [31:0] e_db,
                       input logic e_flag, input logic [31:0] e_addr);
    exp_t e;
    EX_signals = {op, op == 3'b001, mw, 1'b0, ~mw, 1'b0, src, 2'b00};
    EX_func = fn; EX_dataA = a; EX_dataB = b; EX_imm = imm;
    forwardA = fa; forwardB = fb; dataD = dd; EX_pc = pc; EX_Rd = rd;
    e.tag = tag; e.alu = e_alu; e.db = e_db; e.flag = e_flag; e.addr = e_addr;
    e.sig = EX_signals; e.rd = rd;
    sbq.push_back(e);
    step();
  endtask

  typedef struct { logic [3:0] fn; logic [31:0] r; } rt_t;
  rt_t rtab[10];

  initial begin
    rtab[0] = '{4'b0000, 32'd7};  rtab[1] = '{4'b1000, 32'hFFFF_FFFF};
    rtab[2] = '{4'b0001, 32'd48}; rtab[3] = '{4'b0010, 32'd1};
    rtab[4] = '{4'b0011, 32'd1};  rtab[5] = '{4'b0100, 32'd7};
    rtab[6] = '{4'b0101, 32'd0};  rtab[7] = '{4'b1101, 32'd0};
    rtab[8] = '{4'b0110, 32'd7};  rtab[9] = '{4'b0111, 32'd0};

    #1;
    chk("rst_alu", MEM_aluResult, 32'd0);
    chk("rst_sig", {21'd0, MEM_signals}, 32'd0);
    chk("rst_rd", {27'd0, MEM_Rd}, 32'd0);
    chk("rst_db", MEM_dataB, 32'd0);
    @(posedge clock); #1;
    chk("rst_hold_alu", MEM_aluResult, 32'd0);
    clear = 1'b1;

    for (int i = 0; i < 10; i++)
      issue($sformatf("rtype%0d", i), 3'b010, rtab[i].fn, 1'b0, 1'b0, 32'd3, 32'd4, 32'd0,
            2'b00, 2'b00, 32'd0, 32'd0, 5'(i + 1), rtab[i].r, 32'd4, 1'b0, 32'd0);

    // back-to-back dependency through the EX/MEM forward path
    issue("b2b_prod", 3'b010, 4'b0000, 1'b0, 1'b0, 32'd3, 32'd4, 32'd0,
          2'b00, 2'b00, 32'd0, 32'd0, 5'd1, 32'd7, 32'd4, 1'b0, 32'd0);
    issue("b2b_cons", 3'b011, 4'b0000, 1'b1, 1'b0, 32'd0, 32'd9, 32'd1,
          2'b10, 2'b00, 32'd0, 32'd0, 5'd2, 32'd8, 32'd9, 1'b0, 32'd0);
    // forwardB from EX/MEM (holds 8) feeds store data
    issue("fwdb_mem", 3'b000, 4'b0000, 1'b0, 1'b0, 32'd2, 32'd0, 32'd0,
          2'b11, 2'b10, 32'd0, 32'd0, 5'd3, 32'd10, 32'd8, 1'b0, 32'd0);

    issue("itype_bit3", 3'b011, 4'b1000, 1'b1, 1'b0, 32'd3, 32'd0, 32'd4,
          2'b00, 2'b00, 32'd0, 32'd0, 5'd4, 32'd7, 32'd0, 1'b0, 32'd0);
    issue("srai", 3'b011, 4'b1101, 1'b1, 1'b0, 32'h8000_0000, 32'd0, 32'd4,
          2'b00, 2'b00, 32'd0, 32'd0, 5'd4, 32'hF800_0000, 32'd0, 1'b0, 32'd0);
    issue("lui", 3'b100, 4'b0000, 1'b1, 1'b0, 32'd5, 32'd0, 32'h1234_5000,
          2'b00, 2'b00, 32'd0, 32'd0, 5'd5, 32'h1234_5000, 32'd0, 1'b0, 32'd0);
    issue("op101", 3'b101, 4'b0000, 1'b0, 1'b0, 32'd5, 32'd6, 32'd0,
          2'b00, 2'b00, 32'd0, 32'd0, 5'd6, 32'd0, 32'd6, 1'b0, 32'd0);

    issue("bne", 3'b001, 4'b0001, 1'b0, 1'b0, 32'd1, 32'd2, 32'd8,
          2'b00, 2'b00, 32'd0, 32'd2, 5'd0, 32'hFFFF_FFFF, 32'd2, BR, BR ? 32'd4 : 32'd0);
    issue("beq", 3'b001, 4'b0000, 1'b0, 1'b0, 32'd1, 32'd2, 32'd8,
          2'b00, 2'b00, 32'd0, 32'd2, 5'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, BR ? 32'd4 : 32'd0);
    issue("bge_neg", 3'b001, 4'b0101, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0,
          2'b00, 2'b00, 32'd0, 32'd10, 5'd0, 32'hFFFF_FFFE, 32'd1, 1'b0, BR ? 32'd6 : 32'd0);
    issue("bgeu", 3'b001, 4'b0111, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0,
          2'b00, 2'b00, 32'd0, 32'd10, 5'd0, 32'hFFFF_FFFE, 32'd1, BR, BR ? 32'd6 : 32'd0);

    issue("store", 3'b000, 4'b0010, 1'b1, 1'b1, 32'h100, 32'h99, 32'd4,
          2'b00, 2'b01, 32'h55, 32'd0, 5'd0, 32'h104, 32'h55, 1'b0, 32'd0);

    // mid-cycle asynchronous clear, held across an edge, then release
    issue("pre_clr", 3'b000, 4'b0000, 1'b0, 1'b0, 32'd20, 32'd22, 32'd0,
          2'b00, 2'b00, 32'd0, 32'd0, 5'd9, 32'd42, 32'd22, 1'b0, 32'd0);
    #2 clear = 1'b0;
    #1;
    chk("clr_alu", MEM_aluResult, 32'd0);
    chk("clr_db", MEM_dataB, 32'd0);
    chk("clr_sig", {21'd0, MEM_signals}, 32'd0);
    chk("clr_rd", {27'd0, MEM_Rd}, 32'd0);
    @(posedge clock); #1;
    chk("clr_hold_alu", MEM_aluResult, 32'd0);
    clear = 1'b1;
    issue("post_clr", 3'b000, 4'b0000, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0,
          2'b00, 2'b00, 32'd0, 32'd0, 5'd7, 32'd3, 32'd2, 1'b0, 32'd0);

    // load-use hazard detection is purely combinational
    EX_signals = 11'b000_0010_0000; EX_Rd = 5'd5; ID_Rs1 = 5'd1; ID_Rs2 = 5'd5;
    #1 chk("hz_rs2", {31'd0, notStall}, 32'd0);
    ID_Rs1 = 5'd5; ID_Rs2 = 5'd2;
    #1 chk("hz_rs1", {31'd0, notStall}, 32'd0);
    EX_Rd = 5'd0; ID_Rs1 = 5'd0;
    #1 chk("hz_rd0", {31'd0, notStall}, 32'd1);
    EX_Rd = 5'd5; ID_Rs1 = 5'd5; EX_signals = 11'd0;
    #1 chk("hz_nomr", {31'd0, notStall}, 32'd1);
    EX_signals = 11'b000_0010_0000; ID_Rs1 = 5'd6; ID_Rs2 = 5'd7;
    #1 chk("hz_nomatch", {31'd0, notStall}, 32'd1);

    chk("sb_drained", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/riscv_ex_stage.md
# riscv_ex_stage

Execute stage of the 5-stage RV32I pipeline: load-use hazard detection, forwarding operand selection, ALU with branch compare, branch-target adder and the EX/MEM pipeline register. Sits between the ID/EX register and data memory; its registered MEM-side outputs feed data memory, the MEM/WB register, PC-redirect logic and (internally) the forwarding path.

## Interface
- `XLEN`, 32, datapath width.
- `clock`  in  1  pipeline clock, rising edge.
- `clear`  in  1  asynchronous, active-low reset.
- `EX_signals`  in  11  control word: [1:0] immSel, [2] AluSrc, [3] MemToReg, [4] RegWrite, [5] MemRead, [6] MemWrite, [7] Branch, [10:8] AluOp.
- `EX_pc`  in  XLEN  word address of the instruction in EX.
- `EX_dataA`, `EX_dataB`  in  XLEN  register-file operands.
- `EX_imm`  in  XLEN  sign-extended immediate (byte offset).
- `EX_func`  in  4  {instr[30], funct3}.
- `EX_Rd`  in  5  destination register.
- `ID_Rs1`, `ID_Rs2`  in  5  source registers of the instruction in ID.
- `forwardA`, `forwardB`  in  2  forwarding selects.
- `dataD`  in  XLEN  write-back value.
- `notStall`  out  1  0 = stall PC/IF-ID and bubble ID/EX.
- `MEM_signals`  out  11; `MEM_branchAddr`  out  XLEN; `MEM_branchFromAlu`  out  1; `MEM_aluResult`  out  XLEN; `MEM_dataB`  out  XLEN; `MEM_Rd`  out  5.

## Operation
- Hazard: `notStall` = 0 iff EX_signals[5]=1, EX_Rd≠0, and EX_Rd equals ID_Rs1 or ID_Rs2; else 1. Purely combinational.
- Forward mux (A and B identical): 00 → EX_data; 10 → MEM_aluResult (this block's register); 01 → dataD; 11 → EX_data.
- aluA = forwarded A. aluB = EX_imm when AluSrc=1, else forwarded B. Store data = forwarded B (never the immediate).
- AluOp: 000 add; 001 branch (sub, compare); 010 R-type by EX_func; 011 I-type by EX_func (bit3 honoured only for funct3=101); 100 pass aluB (LUI); 101–111 result 0.
- R/I function: add (sub if bit3 and R-type), sll, slt (signed), sltu, xor, srl/sra (bit3), or, and. Shift amount = aluB[4:0]. All arithmetic modulo 2^XLEN.
- Branch flag (AluOp=001 only, else 0): funct3 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu, 010/011 → 0.
- Branch target = EX_pc + (EX_imm >>> 2) (arithmetic, word-addressed PC).
- EX/MEM register captures {EX_signals, target, flag, ALU result, store data, EX_Rd} every rising edge; no enable, no flush input (bubbles arrive as zero control).

## Timing
- HDU, muxes, ALU, adder: combinational, same cycle.
- EX/MEM outputs: 1-cycle latency.
- `clear` low: all MEM_* outputs 0 immediately, held while low; `notStall` stays combinational. Mid-operation reset discards the in-flight instruction.
- Forward from MEM_aluResult uses the value registered at the previous edge (back-to-back dependency).
- Simultaneous MEM and WB match resolved outside (forwardA/B already prioritised).

## Configuration
- `EX_BRANCH_EN` defined: branch flag and target adder as above.
- Undefined: MEM_branchFromAlu and MEM_branchAddr tie to 0; AluOp 001 still performs subtract.

## Test plan
- x1=3, x2=4, AluOp 010, forward 00: func 0000→7, 1000→0xFFFFFFFF, 0001→48, 0010→1, 0011→1, 0100→7, 0101→0, 1101→0, 0110→7, 0111→0, each on MEM_aluResult one edge later.
- Back-to-back: cycle N result 7; cycle N+1 forwardA=10, EX_dataA=0, imm 1, AluSrc 1, AluOp 011 → 8.
- EX_signals[5]=1, EX_Rd=5, ID_Rs2=5 → notStall=0; EX_Rd=0 or MemRead=0 → 1.
- Branch: AluOp 001, func 001, A=1, B=2, EX_pc=2, imm=8 → MEM_branchFromAlu=1, MEM_branchAddr=4; func 000 → flag 0.
- Store: AluSrc 1, forwardB=01, dataD=0x55 → MEM_dataB=0x55, MEM_aluResult=A+imm.
- Pull `clear` low between edges → all MEM_* 0 at once; release, next edge loads normally.
